// File: rtl/ctrl_port_arbiter.sv
// rtl/ctrl_port_arbiter.sv - round-robin arbiter sharing one connection-manager control port
// Keeps one transaction in flight, routes each response back to its issuer, forces timeout completions.
module ctrl_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int KEY_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             s_axis_req_valid,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   s_axis_req_key,
  input  logic [NUM_REQ-1:0]             s_axis_req_activate,
  output logic [NUM_REQ-1:0]             s_axis_req_ready,
  output logic [NUM_REQ-1:0]             m_axis_resp_valid,
  input  logic [NUM_REQ-1:0]             m_axis_resp_ready,
  output logic                           m_axis_resp_ack,
  output logic                           m_axis_resp_full,
  output logic                           m_axis_resp_timeout,
  output logic                           m_axis_ctrl_valid,
  output logic [KEY_WIDTH-1:0]           m_axis_ctrl_key,
  output logic                           m_axis_ctrl_activate,
  input  logic                           m_axis_ctrl_ready,
  input  logic                           s_axis_ctrl_valid,
  input  logic                           s_axis_ctrl_ack,
  input  logic                           s_axis_ctrl_full,
  output logic                           s_axis_ctrl_ready,
  output logic [$clog2(NUM_REQ)-1:0]     grant_idx,
  output logic                           busy,
  output logic [7:0]                     timeout_cnt,
  output logic [7:0]                     stale_cnt
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 act_q, act_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 ack_q, ack_d;
  logic                 full_q, full_d;
  logic                 to_q, to_d;
  logic [7:0]           timeout_cnt_q, timeout_cnt_d;
  logic [7:0]           stale_cnt_q, stale_cnt_d;
  logic                 live_q;

  logic                 found;
  logic [IDX_W-1:0]     grant;
  logic [CW-1:0]        cand;
  logic [KEY_WIDTH-1:0] key_sel;
  logic                 accept;
  logic                 expire;
  logic [TW-1:0]        timer_inc;
  logic [CW-1:0]        nxt_w;
  logic [IDX_W-1:0]     rr_next;

  // Search starts at rr_ptr and wraps modulo NUM_REQ (which need not be a power of two).
  always_comb begin
    found   = 1'b0;
    grant   = rr_ptr_q;
    cand    = '0;
    key_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && s_axis_req_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = cand[IDX_W-1:0];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant == IDX_W'(j)) key_sel = s_axis_req_key[j*KEY_WIDTH +: KEY_WIDTH];
    end
  end

  // live_q keeps every output, including the combinational ready, at 0 through reset.
  assign accept    = (state_q == IDLE) && found && live_q;
  assign expire    = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign timer_inc = expire ? timer_q : timer_q + TW'(1);
  assign nxt_w     = {1'b0, grant_idx_q} + CW'(1);
  assign rr_next   = (nxt_w >= CW'(NUM_REQ)) ? '0 : nxt_w[IDX_W-1:0];

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    key_d         = key_q;
    act_d         = act_q;
    timer_d       = timer_q;
    ack_d         = ack_q;
    full_d        = full_q;
    to_d          = to_q;
    timeout_cnt_d = timeout_cnt_q;
    stale_cnt_d   = stale_cnt_q;
    if (s_axis_ctrl_valid && (state_q != WAIT) && (stale_cnt_q != 8'hFF))
      stale_cnt_d = stale_cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_idx_d = grant;
          key_d       = key_sel;
          act_d       = s_axis_req_activate[grant];
          timer_d     = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        timer_d = timer_inc;
        if (state_q == ISSUE && m_axis_ctrl_ready) begin
          state_d = WAIT;
        end else if (state_q == WAIT && s_axis_ctrl_valid) begin
          ack_d   = s_axis_ctrl_ack;
          full_d  = s_axis_ctrl_full;
          to_d    = 1'b0;
          state_d = RETURN;
        end else if (expire) begin
          ack_d   = 1'b0;
          full_d  = 1'b0;
          to_d    = 1'b1;
          state_d = RETURN;
          if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
      end
      RETURN: begin
        if (m_axis_resp_ready[grant_idx_q]) begin
          rr_ptr_d = rr_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      key_q         <= '0;
      act_q         <= 1'b0;
      timer_q       <= '0;
      ack_q         <= 1'b0;
      full_q        <= 1'b0;
      to_q          <= 1'b0;
      timeout_cnt_q <= '0;
      stale_cnt_q   <= '0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      key_q         <= key_d;
      act_q         <= act_d;
      timer_q       <= timer_d;
      ack_q         <= ack_d;
      full_q        <= full_d;
      to_q          <= to_d;
      timeout_cnt_q <= timeout_cnt_d;
      stale_cnt_q   <= stale_cnt_d;
      live_q        <= 1'b1;
    end
  end

  assign s_axis_req_ready     = accept ? (NUM_REQ'(1) << grant) : '0;
  assign m_axis_resp_valid    = (state_q == RETURN) ? (NUM_REQ'(1) << grant_idx_q) : '0;
  assign m_axis_resp_ack      = ack_q;
  assign m_axis_resp_full     = full_q;
  assign m_axis_resp_timeout  = to_q;
  assign m_axis_ctrl_valid    = (state_q == ISSUE);
  assign m_axis_ctrl_key      = key_q;
  assign m_axis_ctrl_activate = act_q;
  assign s_axis_ctrl_ready    = live_q;
  assign grant_idx            = grant_idx_q;
  assign busy                 = (state_q != IDLE);
  assign timeout_cnt          = timeout_cnt_q;
  assign stale_cnt            = stale_cnt_q;
endmodule
